// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the pipeline/memory side and hazard_ctrl.
// master drives the request/hazard inputs; slave (hazard_ctrl) returns the stall/flush controls.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             im_req;
  logic             im_ready;
  logic             dm_req;
  logic             dm_ready;
  logic             MEM_read_EXE;
  logic [4:0]       write_addr_EXE;
  logic [4:0]       Read_addr_1_ID;
  logic [4:0]       Read_addr_2_ID;
  logic             rs1_used_ID;
  logic             rs2_used_ID;
  logic             branch_taken_EXE;
  logic             jalr_EXE;
  logic             Istall;
  logic             Dstall;
  logic             flush;
  logic             flush_jalr;
  logic             pc_write;
  logic             IF_ID_write;
  logic             bus_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output im_req, im_ready, dm_req, dm_ready, MEM_read_EXE, write_addr_EXE,
           Read_addr_1_ID, Read_addr_2_ID, rs1_used_ID, rs2_used_ID,
           branch_taken_EXE, jalr_EXE,
    input  Istall, Dstall, flush, flush_jalr, pc_write, IF_ID_write, bus_timeout, stall_cnt
  );

  modport slave (
    input  im_req, im_ready, dm_req, dm_ready, MEM_read_EXE, write_addr_EXE,
           Read_addr_1_ID, Read_addr_2_ID, rs1_used_ID, rs2_used_ID,
           branch_taken_EXE, jalr_EXE,
    output Istall, Dstall, flush, flush_jalr, pc_write, IF_ID_write, bus_timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central pipeline control: memory-wait stalls with timeout, load-use bubbles and
// EXE redirects held pending across stalls so they are not lost.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {StIdle, StWait} wait_st_e;

  localparam logic [7:0]       TimeoutVal = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};

  wait_st_e         i_st_q, i_st_d, d_st_q, d_st_d;
  logic [7:0]       wcnt_i_q, wcnt_i_d, wcnt_d_q, wcnt_d_d;
  logic             br_pend_q, jalr_pend_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic istall, dstall, to_i, to_d, stall, redirect, lu;
  logic pc_write_c, if_id_write_c, flush_c, flush_jalr_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_st_q      <= StIdle;
      d_st_q      <= StIdle;
      wcnt_i_q    <= 8'd0;
      wcnt_d_q    <= 8'd0;
      br_pend_q   <= 1'b0;
      jalr_pend_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      i_st_q   <= i_st_d;
      d_st_q   <= d_st_d;
      wcnt_i_q <= wcnt_i_d;
      wcnt_d_q <= wcnt_d_d;
      if (stall) begin
        br_pend_q   <= br_pend_q | bus.branch_taken_EXE;
        jalr_pend_q <= jalr_pend_q | bus.jalr_EXE;
        stall_cnt_q <= stall_cnt_q + CntOne;
      end else begin
        br_pend_q   <= 1'b0;
        jalr_pend_q <= 1'b0;
      end
    end
  end

  // Instruction-side wait FSM; the request is latched by being in StWait.
  always_comb begin
    i_st_d   = i_st_q;
    wcnt_i_d = wcnt_i_q;
    istall   = 1'b0;
    to_i     = 1'b0;
    unique case (i_st_q)
      StIdle: begin
        if (bus.im_req && !bus.im_ready) begin
          istall   = 1'b1;
          i_st_d   = StWait;
          wcnt_i_d = 8'd1;
        end
      end
      StWait: begin
        if (bus.im_ready) begin
          i_st_d = StIdle;
        end else if (wcnt_i_q == TimeoutVal) begin
          i_st_d = StIdle;
          to_i   = 1'b1;
        end else begin
          istall   = 1'b1;
          wcnt_i_d = wcnt_i_q + 8'd1;
        end
      end
      default: i_st_d = StIdle;
    endcase
  end

  always_comb begin
    d_st_d   = d_st_q;
    wcnt_d_d = wcnt_d_q;
    dstall   = 1'b0;
    to_d     = 1'b0;
    unique case (d_st_q)
      StIdle: begin
        if (bus.dm_req && !bus.dm_ready) begin
          dstall   = 1'b1;
          d_st_d   = StWait;
          wcnt_d_d = 8'd1;
        end
      end
      StWait: begin
        if (bus.dm_ready) begin
          d_st_d = StIdle;
        end else if (wcnt_d_q == TimeoutVal) begin
          d_st_d = StIdle;
          to_d   = 1'b1;
        end else begin
          dstall   = 1'b1;
          wcnt_d_d = wcnt_d_q + 8'd1;
        end
      end
      default: d_st_d = StIdle;
    endcase
  end

  assign stall    = istall | dstall;
  assign redirect = bus.branch_taken_EXE | bus.jalr_EXE | br_pend_q | jalr_pend_q;
  assign lu = bus.MEM_read_EXE && (bus.write_addr_EXE != 5'd0) &&
              ((bus.rs1_used_ID && (bus.Read_addr_1_ID == bus.write_addr_EXE)) ||
               (bus.rs2_used_ID && (bus.Read_addr_2_ID == bus.write_addr_EXE)));

  // Redirect outranks load-use: the ID instruction is squashed anyway.
  always_comb begin
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    flush_c       = 1'b0;
    flush_jalr_c  = 1'b0;
    if (stall) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
    end else if (redirect) begin
      flush_c      = bus.branch_taken_EXE | br_pend_q;
      flush_jalr_c = bus.jalr_EXE | jalr_pend_q;
    end else if (lu) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      flush_c       = 1'b1;
    end
  end

  assign bus.Istall      = rst & istall;
  assign bus.Dstall      = rst & dstall;
  assign bus.flush       = rst & flush_c;
  assign bus.flush_jalr  = rst & flush_jalr_c;
  assign bus.pc_write    = rst & pc_write_c;
  assign bus.IF_ID_write = rst & if_id_write_c;
  assign bus.bus_timeout = rst & (to_i | to_d);
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4, CNT_W=8 so the counter wrap is reachable).
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [7:0] exp_cnt;
  logic [6:0] obs;

  hazard_ctrl_if #(.CNT_W(8)) bus ();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {Istall, Dstall, flush, flush_jalr, pc_write, IF_ID_write, bus_timeout}
  assign obs = {bus.Istall, bus.Dstall, bus.flush, bus.flush_jalr,
                bus.pc_write, bus.IF_ID_write, bus.bus_timeout};

  localparam logic [6:0] ONone   = 7'b0000000;
  localparam logic [6:0] ONormal = 7'b0000110;
  localparam logic [6:0] OIst    = 7'b1000000;
  localparam logic [6:0] ODst    = 7'b0100000;
  localparam logic [6:0] OBoth   = 7'b1100000;
  localparam logic [6:0] OTmo    = 7'b0000111;
  localparam logic [6:0] OLu     = 7'b0010000;
  localparam logic [6:0] OBr     = 7'b0010110;
  localparam logic [6:0] OJr     = 7'b0001110;
  localparam logic [6:0] OBrJr   = 7'b0011110;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.im_req = 0; bus.im_ready = 0; bus.dm_req = 0; bus.dm_ready = 0;
    bus.MEM_read_EXE = 0; bus.write_addr_EXE = 5'd0;
    bus.Read_addr_1_ID = 5'd0; bus.Read_addr_2_ID = 5'd0;
    bus.rs1_used_ID = 0; bus.rs2_used_ID = 0;
    bus.branch_taken_EXE = 0; bus.jalr_EXE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    #3;
    n_cmp++;
    if (obs !== ONone) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, ONone);
    end
    n_cmp++;
    if (bus.stall_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt);
    end
    bus.im_req = 1; bus.branch_taken_EXE = 1;
    #1;
    n_cmp++;
    if (obs !== ONone) begin
      n_fail++; $display("FAIL reset_forced_zero: got %b want %b", obs, ONone);
    end
    tick();
    rst = 1;
    idle_inputs();
    #1;
    n_cmp++;
    if (obs !== ONormal) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", obs, ONormal);
    end
    exp_cnt = 8'd0;
    tick();
  endtask

  task automatic test_fetch_wait();
    bus.im_req = 1; bus.im_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (obs !== OIst) begin
        n_fail++; $display("FAIL fetch_wait_c%0d: got %b want %b", i, obs, OIst);
      end
      tick();
    end
    bus.im_ready = 1;
    #1;
    n_cmp++;
    if (obs !== ONormal) begin
      n_fail++; $display("FAIL fetch_ready: got %b want %b", obs, ONormal);
    end
    tick();
    idle_inputs();
    exp_cnt = exp_cnt + 8'd3;
    #1;
    n_cmp++;
    if (bus.stall_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL fetch_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    bus.dm_req = 1; bus.dm_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (obs !== ODst) begin
        n_fail++; $display("FAIL timeout_wait_c%0d: got %b want %b", i, obs, ODst);
      end
      tick();
      bus.dm_req = 0;
    end
    #1;
    n_cmp++;
    if (obs !== OTmo) begin
      n_fail++; $display("FAIL timeout_pulse: got %b want %b", obs, OTmo);
    end
    tick();
    #1;
    n_cmp++;
    if (obs !== ONormal) begin
      n_fail++; $display("FAIL timeout_idle: got %b want %b", obs, ONormal);
    end
    exp_cnt = exp_cnt + 8'd4;
    n_cmp++;
    if (bus.stall_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL timeout_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    bus.MEM_read_EXE = 1; bus.write_addr_EXE = 5'd5;
    bus.Read_addr_1_ID = 5'd3; bus.Read_addr_2_ID = 5'd5;
    bus.rs1_used_ID = 1; bus.rs2_used_ID = 1;
    #1;
    n_cmp++;
    if (obs !== OLu) begin
      n_fail++; $display("FAIL lu_rs2_bubble: got %b want %b", obs, OLu);
    end
    tick();
    bus.MEM_read_EXE = 0;
    #1;
    n_cmp++;
    if (obs !== ONormal) begin
      n_fail++; $display("FAIL lu_after_bubble: got %b want %b", obs, ONormal);
    end
    tick();
    bus.MEM_read_EXE = 1; bus.write_addr_EXE = 5'd0;
    bus.Read_addr_1_ID = 5'd0; bus.Read_addr_2_ID = 5'd0;
    #1;
    n_cmp++;
    if (obs !== ONormal) begin
      n_fail++; $display("FAIL lu_x0: got %b want %b", obs, ONormal);
    end
    tick();
    bus.write_addr_EXE = 5'd7; bus.Read_addr_1_ID = 5'd7; bus.Read_addr_2_ID = 5'd7;
    bus.rs1_used_ID = 1; bus.rs2_used_ID = 0;
    #1;
    n_cmp++;
    if (obs !== OLu) begin
      n_fail++; $display("FAIL lu_rs1_bubble: got %b want %b", obs, OLu);
    end
    tick();
    bus.rs1_used_ID = 0;
    #1;
    n_cmp++;
    if (obs !== ONormal) begin
      n_fail++; $display("FAIL lu_unused_regs: got %b want %b", obs, ONormal);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_redirect_stall(input logic is_jalr);
    logic [6:0] want;
    want = is_jalr ? OJr : OBr;
    bus.im_req = 1; bus.im_ready = 0;
    bus.branch_taken_EXE = !is_jalr; bus.jalr_EXE = is_jalr;
    #1;
    n_cmp++;
    if (obs !== OIst) begin
      n_fail++; $display("FAIL redir_stall_a j=%0b: got %b want %b", is_jalr, obs, OIst);
    end
    tick();
    bus.im_req = 0; bus.branch_taken_EXE = 0; bus.jalr_EXE = 0;
    #1;
    n_cmp++;
    if (obs !== OIst) begin
      n_fail++; $display("FAIL redir_stall_b j=%0b: got %b want %b", is_jalr, obs, OIst);
    end
    tick();
    bus.im_ready = 1;
    #1;
    n_cmp++;
    if (obs !== want) begin
      n_fail++; $display("FAIL redir_pending j=%0b: got %b want %b", is_jalr, obs, want);
    end
    tick();
    bus.im_ready = 0;
    #1;
    n_cmp++;
    if (obs !== ONormal) begin
      n_fail++; $display("FAIL redir_cleared j=%0b: got %b want %b", is_jalr, obs, ONormal);
    end
    exp_cnt = exp_cnt + 8'd2;
    tick();
  endtask

  task automatic test_redirect_priority();
    bus.MEM_read_EXE = 1; bus.write_addr_EXE = 5'd9;
    bus.Read_addr_1_ID = 5'd9; bus.rs1_used_ID = 1;
    bus.jalr_EXE = 1;
    #1;
    n_cmp++;
    if (obs !== OJr) begin
      n_fail++; $display("FAIL prio_jalr_lu: got %b want %b", obs, OJr);
    end
    tick();
    bus.jalr_EXE = 0; bus.branch_taken_EXE = 1;
    #1;
    n_cmp++;
    if (obs !== OBr) begin
      n_fail++; $display("FAIL prio_branch_lu: got %b want %b", obs, OBr);
    end
    tick();
    bus.jalr_EXE = 1;
    #1;
    n_cmp++;
    if (obs !== OBrJr) begin
      n_fail++; $display("FAIL prio_branch_jalr: got %b want %b", obs, OBrJr);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_dual_stall();
    bus.im_req = 1; bus.dm_req = 1;
    #1;
    n_cmp++;
    if (obs !== OBoth) begin
      n_fail++; $display("FAIL dual_stall: got %b want %b", obs, OBoth);
    end
    tick();
    bus.im_req = 0; bus.dm_req = 0; bus.im_ready = 1; bus.dm_ready = 1;
    #1;
    n_cmp++;
    if (obs !== ONormal) begin
      n_fail++; $display("FAIL dual_release: got %b want %b", obs, ONormal);
    end
    tick();
    idle_inputs();
    exp_cnt = exp_cnt + 8'd1;
    n_cmp++;
    if (bus.stall_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL dual_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    bus.dm_req = 1;
    tick();
    bus.dm_req = 0;
    #1;
    n_cmp++;
    if (obs !== ODst) begin
      n_fail++; $display("FAIL areset_in_wait: got %b want %b", obs, ODst);
    end
    #1;
    rst = 0;
    #1;
    n_cmp++;
    if (obs !== ONone) begin
      n_fail++; $display("FAIL areset_outputs: got %b want %b", obs, ONone);
    end
    n_cmp++;
    if (bus.stall_cnt !== 8'd0) begin
      n_fail++; $display("FAIL areset_cnt: got %0d want 0", bus.stall_cnt);
    end
    tick();
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (obs !== ONormal) begin
        n_fail++; $display("FAIL areset_idle_c%0d: got %b want %b", i, obs, ONormal);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 85; r++) begin
      bus.im_req = 1; bus.im_ready = 0;
      tick(); tick(); tick();
      bus.im_ready = 1;
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.stall_cnt !== 8'hff) begin
      n_fail++; $display("FAIL wrap_preload: got %0d want 255", bus.stall_cnt);
    end
    bus.im_req = 1;
    tick();
    bus.im_req = 0; bus.im_ready = 1;
    #1;
    n_cmp++;
    if (bus.stall_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_zero: got %0d want 0", bus.stall_cnt);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (bus.stall_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_hold: got %0d want 0", bus.stall_cnt);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    exp_cnt = 8'd0;
    test_reset();
    test_fetch_wait();
    test_timeout();
    test_load_use();
    test_redirect_stall(1'b0);
    test_redirect_stall(1'b1);
    test_redirect_priority();
    test_dual_stall();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
